pcpu_boot_ctrl: RTL and testbench

//  Boot sequencer for the pcpu system. Accepts a word stream over a valid/ready

---
 rtl/pcpu_boot_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_pcpu_boot_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/pcpu_boot_ctrl.sv
// Boot sequencer: streams header/payload words from a loader into instruction or
// data memory, then releases the pcpu (reset off, enable on, single start pulse).
module pcpu_boot_ctrl #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 16,
    parameter int START_DELAY = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              boot_req,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_last,
    output logic              i_we,
    output logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_wdata,
    output logic              d_we,
    output logic [ADDR_W-1:0] d_addr,
    output logic [DATA_W-1:0] d_wdata,
    output logic              cpu_reset,
    output logic              cpu_enable,
    output logic              cpu_start,
    output logic              busy,
    output logic              wrap_err
);

    localparam int SEG_BIT = 15;
    localparam int END_BIT = 14;
    localparam int CNT_W   = $clog2(START_DELAY + 1) + 1;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HDR  = 3'd1,
        ST_LOAD = 3'd2,
        ST_REL  = 3'd3,
        ST_RUN  = 3'd4
    } state_t;

    state_t            state_r, state_nxt_s;
    logic [ADDR_W-1:0] addr_r, addr_nxt_s;
    logic              seg_r, seg_nxt_s;
    logic [CNT_W-1:0]  cnt_r, cnt_nxt_s;
    logic              boot_q_r;
    logic              xfer_s;
    logic              ready_nxt_s;

    logic              i_we_s, d_we_s;
    logic [ADDR_W-1:0] i_addr_s, d_addr_s;
    logic [DATA_W-1:0] i_wdata_s, d_wdata_s;
    logic              cpu_reset_s, cpu_enable_s, cpu_start_s, busy_s, wrap_err_s;

    // Header bits between the address field and the flags carry no meaning.
    logic              unused_hdr_s;
    assign unused_hdr_s = ^ld_data;

    assign xfer_s      = ld_valid & ld_ready;
    assign ready_nxt_s = (state_nxt_s == ST_HDR) || (state_nxt_s == ST_LOAD);

    // Next-state and next-output decode; outputs are registered below.
    always_comb begin
        state_nxt_s  = state_r;
        addr_nxt_s   = addr_r;
        seg_nxt_s    = seg_r;
        cnt_nxt_s    = cnt_r;
        i_we_s       = 1'b0;
        i_addr_s     = i_addr;
        i_wdata_s    = i_wdata;
        d_we_s       = 1'b0;
        d_addr_s     = d_addr;
        d_wdata_s    = d_wdata;
        cpu_reset_s  = cpu_reset;
        cpu_enable_s = cpu_enable;
        cpu_start_s  = 1'b0;
        busy_s       = busy;
        wrap_err_s   = wrap_err;

        case (state_r)
            ST_IDLE: begin
                if (boot_req) begin
                    state_nxt_s = ST_HDR;
                    busy_s      = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_HDR: begin
                if (xfer_s && ld_data[END_BIT]) begin
                    state_nxt_s = ST_REL;
                    cpu_reset_s = 1'b1;
                    cnt_nxt_s   = {CNT_W{1'b0}};
                end else if (xfer_s) begin
                    seg_nxt_s   = ld_data[SEG_BIT];
                    addr_nxt_s  = ld_data[ADDR_W-1:0];
                    state_nxt_s = ST_LOAD;
                end else begin
                    state_nxt_s = ST_HDR;
                end
            end
            ST_LOAD: begin
                if (xfer_s) begin
                    if (seg_r) begin
                        d_we_s    = 1'b1;
                        d_addr_s  = addr_r;
                        d_wdata_s = ld_data;
                    end else begin
                        i_we_s    = 1'b1;
                        i_addr_s  = addr_r;
                        i_wdata_s = ld_data;
                    end
                    // Write still happens at the top address; the flag records the wrap.
                    addr_nxt_s = addr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
                    if (&addr_r) begin
                        wrap_err_s = 1'b1;
                    end else begin
                        wrap_err_s = wrap_err;
                    end
                    if (ld_last) begin
                        state_nxt_s = ST_HDR;
                    end else begin
                        state_nxt_s = ST_LOAD;
                    end
                end else begin
                    state_nxt_s = ST_LOAD;
                end
            end
            ST_REL: begin
                if (cnt_r == {CNT_W{1'b0}}) begin
                    cpu_enable_s = 1'b1;
                    cnt_nxt_s    = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                end else if (cnt_r == CNT_W'(START_DELAY)) begin
                    cpu_start_s = 1'b1;
                    busy_s      = 1'b0;
                    state_nxt_s = ST_RUN;
                end else begin
                    cnt_nxt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            ST_RUN: begin
                if (boot_req && !boot_q_r) begin
                    cpu_reset_s  = 1'b0;
                    cpu_enable_s = 1'b0;
                    wrap_err_s   = 1'b0;
                    busy_s       = 1'b1;
                    state_nxt_s  = ST_HDR;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State, datapath and output registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r    <= ST_IDLE;
            addr_r     <= {ADDR_W{1'b0}};
            seg_r      <= 1'b0;
            cnt_r      <= {CNT_W{1'b0}};
            boot_q_r   <= 1'b0;
            ld_ready   <= 1'b0;
            i_we       <= 1'b0;
            i_addr     <= {ADDR_W{1'b0}};
            i_wdata    <= {DATA_W{1'b0}};
            d_we       <= 1'b0;
            d_addr     <= {ADDR_W{1'b0}};
            d_wdata    <= {DATA_W{1'b0}};
            cpu_reset  <= 1'b0;
            cpu_enable <= 1'b0;
            cpu_start  <= 1'b0;
            busy       <= 1'b0;
            wrap_err   <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            addr_r     <= addr_nxt_s;
            seg_r      <= seg_nxt_s;
            cnt_r      <= cnt_nxt_s;
            boot_q_r   <= boot_req;
            ld_ready   <= ready_nxt_s;
            i_we       <= i_we_s;
            i_addr     <= i_addr_s;
            i_wdata    <= i_wdata_s;
            d_we       <= d_we_s;
            d_addr     <= d_addr_s;
            d_wdata    <= d_wdata_s;
            cpu_reset  <= cpu_reset_s;
            cpu_enable <= cpu_enable_s;
            cpu_start  <= cpu_start_s;
            busy       <= busy_s;
            wrap_err   <= wrap_err_s;
        end
    end

endmodule

// File: tb/tb_pcpu_boot_ctrl.sv
// Bench for pcpu_boot_ctrl: a timeline/scoreboard model checked every cycle, plus
// hand-computed write-log and release-timing expectations.
module tb_pcpu_boot_ctrl;

    localparam int SD = 2;

    logic        clock = 1'b0;
    logic        reset, boot_req, ld_valid, ld_last;
    logic        ld_ready;
    logic [15:0] ld_data;
    logic        i_we, d_we;
    logic [7:0]  i_addr, d_addr;
    logic [15:0] i_wdata, d_wdata;
    logic        cpu_reset, cpu_enable, cpu_start, busy, wrap_err;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;
    logic [24:0] wlog[$];
    int lb;

    pcpu_boot_ctrl #(.ADDR_W(8), .DATA_W(16), .START_DELAY(SD)) dut (
        .clock(clock), .reset(reset), .boot_req(boot_req),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data), .ld_last(ld_last),
        .i_we(i_we), .i_addr(i_addr), .i_wdata(i_wdata),
        .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .cpu_reset(cpu_reset), .cpu_enable(cpu_enable), .cpu_start(cpu_start),
        .busy(busy), .wrap_err(wrap_err)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Model: phase 0 idle, 1 header, 2 payload, 3 release, 4 running.
    int          phase, cyc, t_end;
    logic        m_seg, m_prev;
    logic [7:0]  m_ptr;
    logic        e_i_we, e_d_we, e_rst, e_en, e_start, e_busy, e_wrap;
    logic [7:0]  e_i_addr, e_d_addr;
    logic [15:0] e_i_wdata, e_d_wdata;
    logic        m_ready;
    assign m_ready = (phase == 1) || (phase == 2);

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            phase <= 0; cyc <= 0; t_end <= 0; m_seg <= 1'b0; m_prev <= 1'b0; m_ptr <= 8'h00;
            e_i_we <= 1'b0; e_d_we <= 1'b0; e_rst <= 1'b0; e_en <= 1'b0; e_start <= 1'b0;
            e_busy <= 1'b0; e_wrap <= 1'b0; e_i_addr <= 8'h00; e_d_addr <= 8'h00;
            e_i_wdata <= 16'h0000; e_d_wdata <= 16'h0000;
        end else begin
            cyc     <= cyc + 1;
            m_prev  <= boot_req;
            e_i_we  <= 1'b0;
            e_d_we  <= 1'b0;
            e_start <= 1'b0;
            if (phase == 0) begin
                if (boot_req) begin phase <= 1; e_busy <= 1'b1; end
            end else if (phase == 1) begin
                if (ld_valid && ld_data[14]) begin
                    phase <= 3; t_end <= cyc; e_rst <= 1'b1;
                end else if (ld_valid) begin
                    m_seg <= ld_data[15]; m_ptr <= ld_data[7:0]; phase <= 2;
                end
            end else if (phase == 2) begin
                if (ld_valid) begin
                    if (m_seg) begin e_d_we <= 1'b1; e_d_addr <= m_ptr; e_d_wdata <= ld_data; end
                    else       begin e_i_we <= 1'b1; e_i_addr <= m_ptr; e_i_wdata <= ld_data; end
                    m_ptr <= m_ptr + 8'd1;
                    if (m_ptr == 8'hFF) e_wrap <= 1'b1;
                    if (ld_last) phase <= 1;
                end
            end else if (phase == 3) begin
                if (cyc == t_end + 1) e_en <= 1'b1;
                if (cyc == t_end + 1 + SD) begin e_start <= 1'b1; e_busy <= 1'b0; phase <= 4; end
            end else if (boot_req && !m_prev) begin
                e_rst <= 1'b0; e_en <= 1'b0; e_wrap <= 1'b0; e_busy <= 1'b1; phase <= 1;
            end
        end
    end

    // Per-cycle comparison against the model, and log of every memory write.
    always @(negedge clock) begin
        if (cmp_en) begin
            chk("ld_ready", ld_ready, m_ready);
            chk("i_we", i_we, e_i_we);
            chk("i_addr", i_addr, e_i_addr);
            chk("i_wdata", i_wdata, e_i_wdata);
            chk("d_we", d_we, e_d_we);
            chk("d_addr", d_addr, e_d_addr);
            chk("d_wdata", d_wdata, e_d_wdata);
            chk("cpu_reset", cpu_reset, e_rst);
            chk("cpu_enable", cpu_enable, e_en);
            chk("cpu_start", cpu_start, e_start);
            chk("busy", busy, e_busy);
            chk("wrap_err", wrap_err, e_wrap);
        end
        if (i_we === 1'b1) wlog.push_back({1'b0, i_addr, i_wdata});
        if (d_we === 1'b1) wlog.push_back({1'b1, d_addr, d_wdata});
    end

    task automatic send(input logic [15:0] d, input logic last);
        int k;
        ld_valid = 1'b1; ld_data = d; ld_last = last; k = 0;
        while (ld_ready !== 1'b1 && k < 20) begin
            @(negedge clock);
            k++;
        end
        if (ld_ready !== 1'b1) chk("ld_ready_timeout", ld_ready, 32'd1);
        @(negedge clock);
    endtask

    task automatic chk_log(input string nm, input int idx, input logic [24:0] exp);
        if (idx < wlog.size()) chk(nm, wlog[idx], exp);
        else chk({nm, "_missing"}, wlog.size(), idx + 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b0; boot_req = 1'b0; ld_valid = 1'b0; ld_data = 16'h0000; ld_last = 1'b0;
        repeat (2) @(negedge clock);
        cmp_en = 1'b1;
        chk("rst_busy", busy, 32'd0);
        chk("rst_ready", ld_ready, 32'd0);
        chk("rst_cpu_reset", cpu_reset, 32'd0);
        // Words offered in IDLE are neither consumed nor written.
        reset = 1'b1; ld_valid = 1'b1; ld_data = 16'h0005;
        repeat (2) @(negedge clock);
        ld_valid = 1'b0;
        chk("idle_no_writes", wlog.size(), 32'd0);
        boot_req = 1'b1;
        @(negedge clock);
        chk("boot_busy", busy, 32'd1);
        chk("boot_ready", ld_ready, 32'd1);

        lb = wlog.size();
        send(16'h0000, 1'b0); send(16'h1111, 1'b0); send(16'h2222, 1'b1);
        ld_valid = 1'b0; ld_last = 1'b0; #1;
        chk_log("instr_w0", lb, {1'b0, 8'h00, 16'h1111});
        chk_log("instr_w1", lb + 1, {1'b0, 8'h01, 16'h2222});

        lb = wlog.size();
        send(16'h8000, 1'b0); send(16'h00AB, 1'b0); send(16'h3C00, 1'b1);
        send(16'h4000, 1'b0);
        ld_valid = 1'b0; ld_last = 1'b0; #1;
        chk_log("data_w0", lb, {1'b1, 8'h00, 16'h00AB});
        chk_log("data_w1", lb + 1, {1'b1, 8'h01, 16'h3C00});
        chk("rel_cpu_reset", cpu_reset, 32'd1);
        chk("rel_enable_low", cpu_enable, 32'd0);
        @(negedge clock);
        chk("rel_enable_high", cpu_enable, 32'd1);
        chk("rel_start_early1", cpu_start, 32'd0);
        @(negedge clock);
        chk("rel_start_early2", cpu_start, 32'd0);
        @(negedge clock);
        chk("rel_start_pulse", cpu_start, 32'd1);
        chk("rel_busy_drop", busy, 32'd0);
        @(negedge clock);
        chk("rel_start_end", cpu_start, 32'd0);

        // Held-high boot_req and offered words in RUN change nothing.
        lb = wlog.size();
        ld_valid = 1'b1; ld_data = 16'h0101;
        repeat (3) @(negedge clock);
        ld_valid = 1'b0;
        chk("run_no_writes", wlog.size(), lb);
        chk("run_enable_held", cpu_enable, 32'd1);

        boot_req = 1'b0; @(negedge clock);
        boot_req = 1'b1; @(negedge clock);
        chk("reboot_cpu_reset", cpu_reset, 32'd0);
        chk("reboot_enable", cpu_enable, 32'd0);
        chk("reboot_busy", busy, 32'd1);

        lb = wlog.size();
        send(16'h00FF, 1'b0); send(16'hAAAA, 1'b0); send(16'hBBBB, 1'b1);
        ld_valid = 1'b0; ld_last = 1'b0; #1;
        chk_log("wrap_w0", lb, {1'b0, 8'hFF, 16'hAAAA});
        chk_log("wrap_w1", lb + 1, {1'b0, 8'h00, 16'hBBBB});
        chk("wrap_flag", wrap_err, 32'd1);

        lb = wlog.size();
        send(16'h8010, 1'b0); send(16'h0A01, 1'b0);
        ld_valid = 1'b0; @(negedge clock);
        send(16'h0A02, 1'b0);
        ld_valid = 1'b0; @(negedge clock);
        send(16'h0A03, 1'b1);
        ld_valid = 1'b0; ld_last = 1'b0; #1;
        chk_log("stall_w0", lb, {1'b1, 8'h10, 16'h0A01});
        chk_log("stall_w1", lb + 1, {1'b1, 8'h11, 16'h0A02});
        chk_log("stall_w2", lb + 2, {1'b1, 8'h12, 16'h0A03});
        chk("stall_count", wlog.size(), lb + 3);
        chk("wrap_sticky", wrap_err, 32'd1);

        send(16'h4000, 1'b0);
        ld_valid = 1'b0;
        repeat (5) @(negedge clock);
        chk("run2_enable", cpu_enable, 32'd1);
        boot_req = 1'b0; @(negedge clock);
        boot_req = 1'b1; @(negedge clock);
        chk("reboot_wrap_clear", wrap_err, 32'd0);

        // Asynchronous reset while a payload word is being offered.
        lb = wlog.size();
        send(16'h0020, 1'b0); send(16'h1234, 1'b0);
        ld_data = 16'h5678;
        #2 reset = 1'b0;
        #1;
        chk("abort_i_we", i_we, 32'd0);
        chk("abort_ready", ld_ready, 32'd0);
        chk("abort_busy", busy, 32'd0);
        repeat (3) @(negedge clock);
        chk_log("abort_w0", lb, {1'b0, 8'h20, 16'h1234});
        chk("abort_count", wlog.size(), lb + 1);
        ld_valid = 1'b0; boot_req = 1'b0;
        reset = 1'b1;
        repeat (2) @(negedge clock);
        chk("abort_idle_ready", ld_ready, 32'd0);
        chk("abort_idle_busy", busy, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
